// File: rtl/mem_burst_arbiter.sv
// Shares one mem_burst read/write port among four requesters (rd0, wr0, rd1, wr1). Build option MEM_ARB_RD_PRIO_EN gives reads strict priority.
// Latency: ack in the IDLE cycle the request is seen, m_*_burst_req the next cycle, finish gated combinationally.
// Backpressure: requests are held until acked; beats flow only when mem_burst raises data_valid/data_req.
module mem_burst_arbiter #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24
) (
    input  logic                       mem_clk,
    input  logic                       rst_n,
    input  logic                       calib_done,
    input  logic [1:0]                 ch_rd_req,
    input  logic [19:0]                ch_rd_len,
    input  logic [2*ADDR_BITS-1:0]     ch_rd_addr,
    output logic [1:0]                 ch_rd_ack,
    output logic [1:0]                 ch_rd_data_valid,
    output logic [MEM_DATA_BITS-1:0]   ch_rd_data,
    output logic [1:0]                 ch_rd_finish,
    input  logic [1:0]                 ch_wr_req,
    input  logic [19:0]                ch_wr_len,
    input  logic [2*ADDR_BITS-1:0]     ch_wr_addr,
    output logic [1:0]                 ch_wr_ack,
    output logic [1:0]                 ch_wr_data_req,
    input  logic [2*MEM_DATA_BITS-1:0] ch_wr_data,
    output logic [1:0]                 ch_wr_finish,
    output logic                       m_rd_burst_req,
    output logic                       m_wr_burst_req,
    output logic [9:0]                 m_rd_burst_len,
    output logic [9:0]                 m_wr_burst_len,
    output logic [ADDR_BITS-1:0]       m_rd_burst_addr,
    output logic [ADDR_BITS-1:0]       m_wr_burst_addr,
    input  logic                       m_rd_burst_data_valid,
    input  logic                       m_wr_burst_data_req,
    input  logic                       m_rd_burst_finish,
    input  logic                       m_wr_burst_finish,
    input  logic [MEM_DATA_BITS-1:0]   m_rd_burst_data,
    output logic [MEM_DATA_BITS-1:0]   m_wr_burst_data,
    output logic [1:0]                 grant_id,
    output logic                       busy
);

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_BUSY, ARB_SKIP} arb_state_t;

    arb_state_t           state, state_nxt;
    logic [3:0]           req_vec;
    logic [1:0]           win_id;
    logic                 win_vld;
    logic [9:0]           win_len;
    logic [ADDR_BITS-1:0] win_addr;
    logic                 take;
    logic                 fin_evt;

    // Requester index doubles as {client, is_write}
    assign req_vec = {ch_wr_req[1], ch_rd_req[1], ch_wr_req[0], ch_rd_req[0]};

`ifdef MEM_ARB_RD_PRIO_EN
    logic last_rd_client, last_wr_client;
    logic rd_client, wr_client;
    logic rd_pend;

    always_comb begin
        rd_pend   = req_vec[0] | req_vec[2];
        rd_client = (req_vec[0] & req_vec[2]) ? ~last_rd_client : req_vec[2];
        wr_client = (req_vec[1] & req_vec[3]) ? ~last_wr_client : req_vec[3];
        win_vld   = |req_vec;
        win_id    = rd_pend ? {rd_client, 1'b0} : {wr_client, 1'b1};
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_client <= 1'b1;
            last_wr_client <= 1'b1;
        end else if (take) begin
            if (win_id[0]) last_wr_client <= win_id[1];
            else           last_rd_client <= win_id[1];
        end
    end
`else
    logic [1:0] last_grant;
    logic [1:0] cand;

    always_comb begin
        win_id  = 2'd0;
        win_vld = 1'b0;
        cand    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!win_vld && req_vec[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n)    last_grant <= 2'd3;
        else if (take) last_grant <= win_id;
    end
`endif

    always_comb begin
        if (win_id[0]) begin
            win_len  = win_id[1] ? ch_wr_len[19:10] : ch_wr_len[9:0];
            win_addr = win_id[1] ? ch_wr_addr[2*ADDR_BITS-1:ADDR_BITS] : ch_wr_addr[ADDR_BITS-1:0];
        end else begin
            win_len  = win_id[1] ? ch_rd_len[19:10] : ch_rd_len[9:0];
            win_addr = win_id[1] ? ch_rd_addr[2*ADDR_BITS-1:ADDR_BITS] : ch_rd_addr[ADDR_BITS-1:0];
        end
    end

    assign take = (state == ARB_IDLE) && calib_done && win_vld;

    always_comb begin
        state_nxt = state;
        ch_rd_ack = 2'b00;
        ch_wr_ack = 2'b00;
        case (state)
            ARB_IDLE: begin
                if (take) begin
                    if (win_id[0]) ch_wr_ack[win_id[1]] = 1'b1;
                    else           ch_rd_ack[win_id[1]] = 1'b1;
                    // mem_burst underflows on a zero length, so never issue one
                    state_nxt = (win_len == 10'd0) ? ARB_SKIP : ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_nxt = ARB_BUSY;
            ARB_BUSY: begin
                if (grant_id[0] ? m_wr_burst_finish : m_rd_burst_finish)
                    state_nxt = ARB_IDLE;
            end
            ARB_SKIP: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB_IDLE;
            grant_id        <= 2'd0;
            m_rd_burst_len  <= '0;
            m_rd_burst_addr <= '0;
            m_wr_burst_len  <= '0;
            m_wr_burst_addr <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                grant_id <= win_id;
                if (win_id[0]) begin
                    m_wr_burst_len  <= win_len;
                    m_wr_burst_addr <= win_addr;
                end else begin
                    m_rd_burst_len  <= win_len;
                    m_rd_burst_addr <= win_addr;
                end
            end
        end
    end

    assign busy           = (state != ARB_IDLE);
    assign m_rd_burst_req = (state == ARB_ISSUE) && !grant_id[0];
    assign m_wr_burst_req = (state == ARB_ISSUE) &&  grant_id[0];

    always_comb begin
        fin_evt = (state == ARB_SKIP) ||
                  ((state == ARB_BUSY) && (grant_id[0] ? m_wr_burst_finish : m_rd_burst_finish));
        ch_rd_finish     = 2'b00;
        ch_wr_finish     = 2'b00;
        ch_rd_data_valid = 2'b00;
        ch_wr_data_req   = 2'b00;
        if (grant_id[0]) begin
            ch_wr_finish[grant_id[1]]   = fin_evt;
            ch_wr_data_req[grant_id[1]] = (state == ARB_BUSY) && m_wr_burst_data_req;
        end else begin
            ch_rd_finish[grant_id[1]]     = fin_evt;
            ch_rd_data_valid[grant_id[1]] = (state == ARB_BUSY) && m_rd_burst_data_valid;
        end
    end

    assign ch_rd_data      = m_rd_burst_data;
    assign m_wr_burst_data = grant_id[1] ? ch_wr_data[2*MEM_DATA_BITS-1:MEM_DATA_BITS]
                                         : ch_wr_data[MEM_DATA_BITS-1:0];

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter; mem_burst is played by the stimulus sequence.
module tb_mem_burst_arbiter;

    localparam int DW = 64;
    localparam int AW = 24;

    logic          mem_clk = 1'b0;
    logic          rst_n;
    logic          calib_done;
    logic [1:0]    ch_rd_req, ch_wr_req;
    logic [19:0]   ch_rd_len, ch_wr_len;
    logic [2*AW-1:0] ch_rd_addr, ch_wr_addr;
    logic [1:0]    ch_rd_ack, ch_wr_ack, ch_rd_data_valid, ch_rd_finish;
    logic [1:0]    ch_wr_data_req, ch_wr_finish;
    logic [DW-1:0] ch_rd_data;
    logic [2*DW-1:0] ch_wr_data;
    logic          m_rd_burst_req, m_wr_burst_req;
    logic [9:0]    m_rd_burst_len, m_wr_burst_len;
    logic [AW-1:0] m_rd_burst_addr, m_wr_burst_addr;
    logic          m_rd_burst_data_valid, m_wr_burst_data_req;
    logic          m_rd_burst_finish, m_wr_burst_finish;
    logic [DW-1:0] m_rd_burst_data, m_wr_burst_data;
    logic [1:0]    grant_id;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 mem_clk = ~mem_clk;

    mem_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n), .calib_done(calib_done),
        .ch_rd_req(ch_rd_req), .ch_rd_len(ch_rd_len), .ch_rd_addr(ch_rd_addr),
        .ch_rd_ack(ch_rd_ack), .ch_rd_data_valid(ch_rd_data_valid),
        .ch_rd_data(ch_rd_data), .ch_rd_finish(ch_rd_finish),
        .ch_wr_req(ch_wr_req), .ch_wr_len(ch_wr_len), .ch_wr_addr(ch_wr_addr),
        .ch_wr_ack(ch_wr_ack), .ch_wr_data_req(ch_wr_data_req),
        .ch_wr_data(ch_wr_data), .ch_wr_finish(ch_wr_finish),
        .m_rd_burst_req(m_rd_burst_req), .m_wr_burst_req(m_wr_burst_req),
        .m_rd_burst_len(m_rd_burst_len), .m_wr_burst_len(m_wr_burst_len),
        .m_rd_burst_addr(m_rd_burst_addr), .m_wr_burst_addr(m_wr_burst_addr),
        .m_rd_burst_data_valid(m_rd_burst_data_valid),
        .m_wr_burst_data_req(m_wr_burst_data_req),
        .m_rd_burst_finish(m_rd_burst_finish), .m_wr_burst_finish(m_wr_burst_finish),
        .m_rd_burst_data(m_rd_burst_data), .m_wr_burst_data(m_wr_burst_data),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow a further 1 ns settle.
    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch_rd_req = 2'b00; ch_wr_req = 2'b00;
        ch_rd_len = '0; ch_wr_len = '0; ch_rd_addr = '0; ch_wr_addr = '0;
        ch_wr_data = '0;
        m_rd_burst_data_valid = 1'b0; m_wr_burst_data_req = 1'b0;
        m_rd_burst_finish = 1'b0; m_wr_burst_finish = 1'b0;
        m_rd_burst_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [2:0] ack_code(input logic [1:0] ra, input logic [1:0] wa);
        if (ra == 2'b01) return 3'd0;
        if (wa == 2'b01) return 3'd1;
        if (ra == 2'b10) return 3'd2;
        if (wa == 2'b10) return 3'd3;
        return 3'd7;
    endfunction

    initial begin
        logic [1:0]  exp_order [4];
        logic [3:0]  pend;
        logic [63:0] w0, w1;
        int          cnt, cnt2;

        rst_n = 1'b0;
        calib_done = 1'b0;
        clear_inputs();
        #3;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_grant", 64'(grant_id), 64'd0);
        chk("reset_mreq", 64'({m_rd_burst_req, m_wr_burst_req}), 64'd0);
        chk("reset_mlen", 64'({m_rd_burst_len, m_wr_burst_len}), 64'd0);
        chk("reset_maddr", 64'({m_rd_burst_addr, m_wr_burst_addr}), 64'd0);
        tick();
        rst_n = 1'b1;
        calib_done = 1'b1;
        tick();

        // single read rd0 len=4 addr=0x100, with a stray write finish in the middle
        ch_rd_req = 2'b01; ch_rd_len = {10'd0, 10'd4}; ch_rd_addr = {24'h0, 24'h000100};
        #1;
        chk("rd0_ack", 64'(ch_rd_ack), 64'h1);
        tick();
        ch_rd_req = 2'b00;
        #1;
        chk("rd0_mreq", 64'(m_rd_burst_req), 64'd1);
        chk("rd0_maddr", 64'(m_rd_burst_addr), 64'h100);
        chk("rd0_mlen", 64'(m_rd_burst_len), 64'd4);
        chk("rd0_grant", 64'(grant_id), 64'd0);
        tick();
        m_wr_burst_finish = 1'b1;
        #1;
        chk("rd0_pulse_len", 64'(m_rd_burst_req), 64'd0);
        chk("rd0_wrong_dir_fin", 64'({ch_rd_finish, ch_wr_finish}), 64'd0);
        tick();
        m_wr_burst_finish = 1'b0;
        #1;
        chk("rd0_still_busy", 64'(busy), 64'd1);
        for (int b = 0; b < 4; b++) begin
            m_rd_burst_data_valid = 1'b1;
            m_rd_burst_data = 64'hD000_0000_0000_0000 + 64'(b);
            #1;
            chk("rd0_beat_vld", 64'(ch_rd_data_valid), 64'h1);
            chk("rd0_beat_dat", ch_rd_data, 64'hD000_0000_0000_0000 + 64'(b));
            tick();
        end
        m_rd_burst_data_valid = 1'b0;
        m_rd_burst_finish = 1'b1;
        #1;
        chk("rd0_finish", 64'(ch_rd_finish), 64'h1);
        tick();
        m_rd_burst_finish = 1'b0;
        #1;
        chk("rd0_idle", 64'({busy, ch_rd_finish}), 64'd0);

        // all four requesting after reset
        do_reset();
`ifdef MEM_ARB_RD_PRIO_EN
        exp_order[0] = 2'd0; exp_order[1] = 2'd2; exp_order[2] = 2'd1; exp_order[3] = 2'd3;
`else
        exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2; exp_order[3] = 2'd3;
`endif
        pend = 4'b1111;
        ch_rd_len = {10'd1, 10'd1}; ch_wr_len = {10'd1, 10'd1};
        ch_rd_addr = {24'h000200, 24'h000100}; ch_wr_addr = {24'h000400, 24'h000300};
        for (int k = 0; k < 4; k++) begin
            ch_rd_req = {pend[2], pend[0]};
            ch_wr_req = {pend[3], pend[1]};
            #1;
            chk("rr_ack_order", 64'(ack_code(ch_rd_ack, ch_wr_ack)), 64'(exp_order[k]));
            tick();
            pend[exp_order[k]] = 1'b0;
            ch_rd_req = {pend[2], pend[0]};
            ch_wr_req = {pend[3], pend[1]};
            #1;
            chk("rr_grant", 64'(grant_id), 64'(exp_order[k]));
            chk("rr_mreq", 64'({m_wr_burst_req, m_rd_burst_req}),
                exp_order[k][0] ? 64'h2 : 64'h1);
            tick();
            if (exp_order[k][0]) m_wr_burst_finish = 1'b1;
            else                 m_rd_burst_finish = 1'b1;
            tick();
            m_wr_burst_finish = 1'b0;
            m_rd_burst_finish = 1'b0;
        end

        // wr1 len=8 with toggling data requests
        ch_wr_req = 2'b10; ch_wr_len = {10'd8, 10'd0}; ch_wr_addr = {24'h00ABC0, 24'h0};
        #1;
        chk("wr1_ack", 64'(ch_wr_ack), 64'h2);
        tick();
        ch_wr_req = 2'b00;
        #1;
        chk("wr1_mreq", 64'({m_wr_burst_req, m_rd_burst_req}), 64'h2);
        chk("wr1_mlen", 64'(m_wr_burst_len), 64'd8);
        chk("wr1_maddr", 64'(m_wr_burst_addr), 64'h00ABC0);
        tick();
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            w0 = 64'hAAAA_0000_0000_0000 + 64'(c);
            w1 = 64'h1111_0000_0000_0000 + 64'(c);
            ch_wr_data = {w1, w0};
            m_wr_burst_data_req = c[0];
            #1;
            chk("wr1_dreq", 64'(ch_wr_data_req), c[0] ? 64'h2 : 64'h0);
            chk("wr1_data", m_wr_burst_data, w1);
            if (ch_wr_data_req[1]) cnt++;
            tick();
        end
        m_wr_burst_data_req = 1'b0;
        chk("wr1_beats", 64'(cnt), 64'd8);
        m_wr_burst_finish = 1'b1;
        #1;
        chk("wr1_finish", 64'(ch_wr_finish), 64'h2);
        tick();
        m_wr_burst_finish = 1'b0;

        // rd1 zero length: finish once, mem_burst never requested
        ch_rd_req = 2'b10; ch_rd_len = {10'd0, 10'd5};
        #1;
        chk("zl_ack", 64'(ch_rd_ack), 64'h2);
        tick();
        ch_rd_req = 2'b00;
        cnt = 0; cnt2 = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (ch_rd_finish == 2'b10) cnt++;
            if (m_rd_burst_req || m_wr_burst_req) cnt2++;
            tick();
        end
        chk("zl_finish_cnt", 64'(cnt), 64'd1);
        chk("zl_no_mreq", 64'(cnt2), 64'd0);
        chk("zl_idle", 64'(busy), 64'd0);

        // calib_done low blocks grants; falling mid-burst does not abort
        calib_done = 1'b0;
        ch_rd_req = 2'b01; ch_rd_len = {10'd0, 10'd2}; ch_rd_addr = {24'h0, 24'h000777};
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ch_rd_ack != 2'b00 || busy) cnt++;
            tick();
        end
        chk("calib_blocked", 64'(cnt), 64'd0);
        calib_done = 1'b1;
        #1;
        chk("calib_ack", 64'(ch_rd_ack), 64'h1);
        tick();
        ch_rd_req = 2'b00;
        tick();
        calib_done = 1'b0;
        tick();
        #1;
        chk("calib_drop_busy", 64'(busy), 64'd1);
        m_rd_burst_finish = 1'b1;
        #1;
        chk("calib_drop_fin", 64'(ch_rd_finish), 64'h1);
        tick();
        m_rd_burst_finish = 1'b0;
        calib_done = 1'b1;

        // async reset during a len=16 read
        ch_rd_req = 2'b01; ch_rd_len = {10'd0, 10'd16}; ch_rd_addr = {24'h0, 24'h000A00};
        tick();
        ch_rd_req = 2'b00;
        tick();
        m_rd_burst_data_valid = 1'b1;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_grant", 64'(grant_id), 64'd0);
        chk("arst_mlen_addr", 64'({m_rd_burst_len, m_rd_burst_addr}), 64'd0);
        chk("arst_vld", 64'(ch_rd_data_valid), 64'd0);
        m_rd_burst_data_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            m_rd_burst_finish = c[0];
            #1;
            if (ch_rd_finish != 2'b00 || busy) cnt++;
            tick();
        end
        m_rd_burst_finish = 1'b0;
        chk("arst_no_stray_fin", 64'(cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
